din_feeder: RTL and testbench

Input-side feeder for the FIR datapath: it accepts a serial sample stream, packs UNR consecutive samples into one parallel word, and buffers the words in a small first-word-fall-through FIFO. It presents each word as `dout[UNR]` with `FIFO_VALID` to the frame controller/datapath, which consumes words with `SYNC_READY`. It runs a frame of exactly DLEN words per start request and signals completion with `DONE`.

---
 rtl/din_feeder_if.sv | 26 ++
 rtl/din_feeder.sv | 217 +++++++++++++++++++++
 tb/tb_din_feeder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/din_feeder_if.sv
// Stream bundle for din_feeder: serial sample input and parallel FIFO word output.
// The master modport is the feeder side; the slave modport is the producer/consumer side.
interface din_feeder_if #(
    parameter int unsigned DWIDTH = 14,
    parameter int unsigned UNR    = 4,
    parameter int unsigned DEPTH  = 8
);
    logic [DWIDTH-1:0]          s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [UNR-1:0][DWIDTH-1:0] dout;
    logic                       fifo_valid;
    logic                       sync_ready;
    logic                       done;
    logic [$clog2(DEPTH):0]     fill;

    modport master (
        input  s_data, s_valid, sync_ready,
        output s_ready, dout, fifo_valid, done, fill
    );

    modport slave (
        output s_data, s_valid, sync_ready,
        input  s_ready, dout, fifo_valid, done, fill
    );
endinterface

// File: rtl/din_feeder.sv
// Packs UNR serial samples per word into a first-word-fall-through FIFO and runs one DLEN-word frame per start.
// Optional zero-word preroll ahead of each frame is enabled by defining DIN_FEEDER_PREROLL_EN.
module din_feeder #(
    parameter int unsigned DWIDTH = 14,
    parameter int unsigned UNR    = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NTAPS  = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         async_start_i,
    input  logic [31:0]  dlen_i,
    din_feeder_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = (UNR > 1) ? $clog2(UNR) : 1;
`ifdef DIN_FEEDER_PREROLL_EN
    localparam int unsigned PRE_EN = 1;
`else
    localparam int unsigned PRE_EN = 0;
`endif
    localparam int unsigned   NPRE      = PRE_EN * ((NTAPS - 1 + UNR - 1) / UNR);
    localparam logic [31:0]   NPRE_W    = 32'(NPRE);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] DEPTH_W   = PW'(DEPTH);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [LW-1:0] LANE_LAST = LW'(UNR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       sync1_q, sync2_q, level_q;
    logic [31:0]                wlen_q, wlen_d;
    logic [31:0]                wpush_q, wpush_d;
    logic [31:0]                pre_q, pre_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [UNR-1:0][DWIDTH-1:0] pack_q, pack_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [UNR-1:0][DWIDTH-1:0] mem_q [DEPTH];

    logic                       rise_s, fall_s;
    logic [PW-1:0]              fill_s;
    logic                       pre_busy_s, s_ready_s, accept_s, pop_s;
    logic                       push_s, flush_s;
    logic [UNR-1:0][DWIDTH-1:0] push_word_s;

    assign rise_s     = sync2_q & ~level_q;
    assign fall_s     = ~sync2_q & level_q;
    assign fill_s     = wr_ptr_q - rd_ptr_q;
    assign pre_busy_s = (state_q == S_RUN) && (pre_q != 32'd0);
    // Full is judged on the registered occupancy, so a same-cycle pop never frees a slot early.
    assign s_ready_s  = (state_q == S_RUN) && (fill_s < DEPTH_W) && (wpush_q < wlen_q) && !pre_busy_s;
    assign accept_s   = s_ready_s && bus.s_valid;
    assign pop_s      = (fill_s != '0) && bus.sync_ready;

    assign bus.s_ready    = s_ready_s;
    assign bus.fifo_valid = (fill_s != '0);
    assign bus.dout       = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.done       = (state_q == S_FIN);
    assign bus.fill       = fill_s;

    // Two-flop synchronizer for the start level plus the previous-level register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= async_start_i;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
        end
    end

    // Frame state, packer and FIFO pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wlen_q   <= 32'd0;
            wpush_q  <= 32'd0;
            pre_q    <= 32'd0;
            lane_q   <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wlen_q   <= wlen_d;
            wpush_q  <= wpush_d;
            pre_q    <= pre_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so dout reads zero until the first word lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word_s;
        end
    end

    // Next-state, packer, preroll and pointer update logic
    always_comb begin
        state_d     = state_q;
        wlen_d      = wlen_q;
        wpush_d     = wpush_q;
        pre_d       = pre_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_s      = 1'b0;
        push_word_s = pack_q;
        flush_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    wlen_d  = dlen_i;
                    wpush_d = 32'd0;
                    pre_d   = NPRE_W;
                    if ((dlen_i == 32'd0) && (NPRE_W == 32'd0)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (fall_s) begin
                    flush_s = 1'b1;
                end else if (!pre_busy_s && (wpush_q == wlen_q)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (fall_s) begin
                    flush_s = 1'b1;
                end else if (fill_s == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pre_busy_s) begin
            if (fill_s < DEPTH_W) begin
                push_s      = 1'b1;
                push_word_s = '0;
                pre_d       = pre_q - 32'd1;
            end else begin
                push_s = 1'b0;
            end
        end else if (accept_s) begin
            // The last lane bypasses pack_q so the word is pushed in the same cycle.
            if (lane_q == LANE_LAST) begin
                push_s                 = 1'b1;
                push_word_s[UNR-1]     = bus.s_data;
                lane_d                 = '0;
                wpush_d                = wpush_q + 32'd1;
            end else begin
                pack_d[lane_q] = bus.s_data;
                lane_d         = lane_q + LANE_ONE;
            end
        end else begin
            lane_d = lane_q;
        end

        if (flush_s) begin
            state_d  = S_IDLE;
            wlen_d   = 32'd0;
            wpush_d  = 32'd0;
            pre_d    = 32'd0;
            lane_d   = '0;
            pack_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            push_s   = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end
endmodule

// File: tb/tb_din_feeder.sv
// Bench for din_feeder: a table of frames checked against a queue-based word model,
// plus hand-written sequences for start latency, mid-frame reset and push/pop at DEPTH-1.
module tb_din_feeder;
    localparam int DWIDTH = 14;
    localparam int UNR    = 4;
    localparam int DEPTH  = 8;
    localparam int NTAPS  = 37;
`ifdef DIN_FEEDER_PREROLL_EN
    localparam int NPRE = (NTAPS - 1 + UNR - 1) / UNR;
`else
    localparam int NPRE = 0;
`endif
    localparam int BUDGET = 3000;
    localparam int NROWS  = 9;

    typedef logic [UNR-1:0][DWIDTH-1:0] word_t;
    typedef struct {
        int dlen;
        int vpct;
        int rpct;
        int stall;
        int abort_at;
        int base;
        int exp_pops;
        int exp_dones;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dlen;
    int          checks = 0;
    int          failures = 0;
    frame_t      tbl [NROWS];

    din_feeder_if #(.DWIDTH(DWIDTH), .UNR(UNR), .DEPTH(DEPTH)) bus ();

    din_feeder #(.DWIDTH(DWIDTH), .UNR(UNR), .DEPTH(DEPTH), .NTAPS(NTAPS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .async_start_i (start),
        .dlen_i        (dlen),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic word_t mkword(input int base);
        word_t w;
        for (int i = 0; i < UNR; i++) w[i] = DWIDTH'(base + i);
        return w;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_fifo_valid"}, bus.fifo_valid, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_fill"}, bus.fill, 0);
        chk({tag, "_dout"}, bus.dout, 0);
    endtask

    // One frame against the model: expected words come from grouping accepted samples by UNR.
    task automatic run_frame(input frame_t f, output int pops, output int dones);
        word_t             expq[$];
        word_t             cur;
        logic [DWIDTH-1:0] nxt;
        int lane, acc, mfill, total, last_pop_it, done_it, ab_it, stall_acc;
        bit aborted, push_now;
        total     = f.dlen * UNR;
        stall_acc = (NPRE >= DEPTH) ? 0 : (DEPTH - NPRE) * UNR;
        for (int i = 0; i < NPRE; i++) expq.push_back('0);
        nxt = DWIDTH'(f.base);
        cur = '0;
        lane = 0; acc = 0; mfill = 0; pops = 0; dones = 0;
        last_pop_it = -10; done_it = -1; ab_it = -1; aborted = 1'b0;
        dlen = f.dlen;
        start = 1'b1;
        for (int it = 0; it < BUDGET; it++) begin
            if (bus.done) begin
                dones++;
                if (done_it < 0) done_it = it;
                if (pops > 0 && !aborted) chk("done_timing", it, last_pop_it + 2);
            end
`ifndef DIN_FEEDER_PREROLL_EN
            if (!aborted) begin
                chk("fill", bus.fill, mfill);
                chk("fifo_valid", bus.fifo_valid, mfill != 0);
            end
`endif
            if (bus.s_ready) chk("ready_rule", (mfill < DEPTH) && (acc < total), 1);
            if (f.stall > 0 && it == f.stall) begin
                chk("stall_fill", bus.fill, DEPTH);
                chk("stall_ready", bus.s_ready, 0);
                chk("stall_accepted", acc, stall_acc);
            end
            if (aborted && it == ab_it + 6) begin
                chk("abort_fill", bus.fill, 0);
                chk("abort_valid", bus.fifo_valid, 0);
                chk("abort_ready", bus.s_ready, 0);
                break;
            end
            if (done_it >= 0 && it >= done_it + 3) break;

            bus.s_valid    = ($urandom_range(99) < f.vpct);
            bus.s_data     = nxt;
            bus.sync_ready = !aborted && (it >= f.stall) && ($urandom_range(99) < f.rpct);

            push_now = 1'b0;
            if (bus.s_valid && bus.s_ready) begin
                cur[lane] = nxt;
                nxt++;
                acc++;
                lane++;
                if (lane == UNR) begin
                    expq.push_back(cur);
                    lane = 0;
                    push_now = 1'b1;
                end
            end
            if (bus.fifo_valid && bus.sync_ready) begin
                if (expq.size() == 0) chk("pop_model_size", expq.size(), 1);
                else chk("dout", bus.dout, expq.pop_front());
                pops++;
                last_pop_it = it;
                mfill--;
            end
            if (push_now) mfill++;
            if (f.abort_at > 0 && !aborted && pops == f.abort_at) begin
                start   = 1'b0;
                aborted = 1'b1;
                ab_it   = it;
            end
            tick();
        end
        if (!aborted) chk("samples_accepted", acc, total);
        start          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.sync_ready = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int n, d, acc, p, dn;
        bit hit;

        tbl[0] = '{2,   100, 100, 0,  0, 1,     2 + NPRE,  1};
        tbl[1] = '{12,  100, 100, 60, 0, 1,     12 + NPRE, 1};
        tbl[2] = '{10,  100, 60,  0,  5, 1,     5,         0};
        tbl[3] = '{3,   100, 100, 0,  0, 1,     3 + NPRE,  1};
        tbl[4] = '{0,   100, 100, 0,  0, 1,     NPRE,      1};
        tbl[5] = '{7,   70,  40,  0,  0, 4000,  7 + NPRE,  1};
        tbl[6] = '{20,  50,  90,  0,  0, 9000,  20 + NPRE, 1};
        tbl[7] = '{16,  90,  30,  0,  0, 16370, 16 + NPRE, 1};
        tbl[8] = '{1,   30,  100, 0,  0, 222,   1 + NPRE,  1};

        rst_n = 1'b0;
        start = 1'b0;
        dlen = 32'd0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.sync_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) tick();

        // Start latency, then reset mid-frame with three words buffered.
        dlen = 32'd4;
        start = 1'b1;
        n = 0;
        while (!(bus.s_ready || bus.fill != 0) && n < 10) begin
            tick();
            n++;
        end
        chk("start_latency_in_range", (n >= 2) && (n <= 3 + (NPRE > 0 ? 1 : 0)), 1);
        bus.s_valid = 1'b1;
        d = 1;
        n = 0;
        while (bus.fill != 3 && n < 100) begin
            bus.s_data = DWIDTH'(d);
            if (bus.s_ready) d++;
            tick();
            n++;
        end
        chk("pre_reset_fill", bus.fill, 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        start = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_reset_ready", bus.s_ready, 0);
        chk("post_reset_fill", bus.fill, 0);

        for (int r = 0; r < NROWS; r++) begin
            run_frame(tbl[r], p, dn);
            chk($sformatf("row%0d_pops", r), p, tbl[r].exp_pops);
            chk($sformatf("row%0d_dones", r), dn, tbl[r].exp_dones);
        end

`ifndef DIN_FEEDER_PREROLL_EN
        // Push and pop on the same edge while FILL sits at DEPTH-1.
        dlen = 32'd12;
        start = 1'b1;
        bus.s_valid = 1'b1;
        d = 1;
        acc = 0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            bus.s_data = DWIDTH'(d);
            if (bus.fill == DEPTH - 1 && (acc % UNR) == UNR - 1 && bus.s_ready) begin
                chk("pp_head", bus.dout, mkword(1));
                bus.sync_ready = 1'b1;
                hit = 1'b1;
            end
            if (bus.s_valid && bus.s_ready) begin
                d++;
                acc++;
            end
            tick();
            bus.sync_ready = 1'b0;
        end
        chk("pp_reached", hit, 1);
        chk("pp_fill", bus.fill, DEPTH - 1);
        chk("pp_next_head", bus.dout, mkword(5));
        start = 1'b0;
        bus.s_valid = 1'b0;
        repeat (8) tick();
        chk("pp_abort_fill", bus.fill, 0);
        chk("pp_abort_done", bus.done, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
